// File: rtl/lp805x_sfr_init.sv
// lp805x_sfr_init: queued SFR bus initiator acting as a second SFR master
module lp805x_sfr_init #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rsti_n,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic       i_cmd_rd,
    input  logic [7:0] i_cmd_addr,
    input  logic [7:0] i_cmd_data,
    output logic       o_bus_req,
    input  logic       i_bus_gnt,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_rd_addr,
    output logic [7:0] o_data_out,
    output logic       o_wr,
    output logic       o_rd,
    output logic       o_wr_bit,
    output logic       o_rd_bit,
    input  logic [7:0] i_data_in,
    output logic       o_rsp_valid,
    output logic [7:0] o_rsp_addr,
    output logic [7:0] o_rsp_data,
    output logic       o_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WRITE, S_READ, S_CAPTURE} state_t;
    state_t        r_state;
    logic [16:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic          r_bus_req, r_wr, r_rd, r_rsp_valid;
    logic [7:0]    r_wr_addr, r_rd_addr, r_data_out, r_rsp_addr, r_rsp_data;
    logic [16:0]   w_head;
    logic          w_full, w_push, w_pop;
    assign w_head      = r_mem[r_rptr];
    assign w_full      = r_count == (AW+1)'(FIFO_DEPTH);
    assign w_push      = i_cmd_valid & ~w_full & i_rsti_n;
    assign w_pop       = (r_state == S_WRITE) | (r_state == S_CAPTURE);
    assign o_cmd_ready = ~w_full;
    assign o_busy      = (r_count != '0) | (r_state != S_IDLE);
    assign o_wr_bit    = 1'b0;
    assign o_rd_bit    = 1'b0;
    assign o_bus_req   = r_bus_req;
    assign o_wr        = r_wr;
    assign o_rd        = r_rd;
    assign o_wr_addr   = r_wr_addr;
    assign o_rd_addr   = r_rd_addr;
    assign o_data_out  = r_data_out;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_addr  = r_rsp_addr;
    assign o_rsp_data  = r_rsp_data;
    // Command storage {rd, addr, data}; flushing is done by clearing the pointers
    always_ff @(posedge i_clk)
        if (w_push) r_mem[r_wptr] <= {i_cmd_rd, i_cmd_addr, i_cmd_data};
    // FIFO pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge i_clk) begin
        if (!i_rsti_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            if (w_push != w_pop) r_count <= w_push ? r_count + (AW+1)'(1) : r_count - (AW+1)'(1);
        end
    end
    // Bus FSM; every bus output is registered and loaded on the transition into its state
    always_ff @(posedge i_clk) begin
        if (!i_rsti_n) begin
            r_state     <= S_IDLE;
            r_bus_req   <= 1'b0;
            r_wr        <= 1'b0;
            r_rd        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_wr_addr   <= 8'h00;
            r_rd_addr   <= 8'h00;
            r_data_out  <= 8'h00;
            r_rsp_addr  <= 8'h00;
            r_rsp_data  <= 8'h00;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (r_count != '0) begin
                    r_state   <= S_REQ;
                    r_bus_req <= 1'b1;
                end
                S_REQ: if (i_bus_gnt) begin
                    r_state    <= w_head[16] ? S_READ : S_WRITE;
                    r_wr       <= ~w_head[16];
                    r_rd       <= w_head[16];
                    r_wr_addr  <= w_head[16] ? 8'h00 : w_head[15:8];
                    r_data_out <= w_head[16] ? 8'h00 : w_head[7:0];
                    r_rd_addr  <= w_head[16] ? w_head[15:8] : 8'h00;
                end
                S_WRITE: begin
                    r_state    <= S_IDLE;
                    r_bus_req  <= 1'b0;
                    r_wr       <= 1'b0;
                    r_wr_addr  <= 8'h00;
                    r_data_out <= 8'h00;
                end
                S_READ: begin
                    r_state   <= S_CAPTURE;
                    r_rd      <= 1'b0;
                    r_rd_addr <= 8'h00;
                end
                S_CAPTURE: begin
                    r_state     <= S_IDLE;
                    r_bus_req   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_addr  <= w_head[15:8];
                    r_rsp_data  <= i_data_in;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
